// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues in-order imem requests
// and buffers returned words in front of the F/D register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fpc;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   pcq       [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [7:0]    discard;
  logic [CW:0]   occ;
  logic          issue;
  logic          accept;
  logic          drop;
  logic          pop;
  logic          valid;
  logic [31:0]   head_pc;
  logic          unused_tgt;

  // Credits cover buffered plus in-flight words, so a push never overflows.
  assign occ       = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = !rst && !PCSrcE && (occ < (CW+1)'(DEPTH));
  assign imem_addr = fpc;

  assign issue  = imem_req && imem_gnt;
  assign drop   = imem_rvalid && (discard != 8'd0);
  assign accept = imem_rvalid && (discard == 8'd0) && !PCSrcE;
  assign valid  = (count != '0);
  assign pop    = !StallF && valid && !PCSrcE;

  assign head_pc  = buf_pc[rd_ptr];
  assign ValidF   = valid;
  assign InstrF   = valid ? buf_instr[rd_ptr] : NOP;
  assign PCF      = valid ? head_pc : 32'd0;
  assign PCPlus4F = valid ? head_pc + 32'd4 : 32'd0;

  assign unused_tgt = ^PCTargetE[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= 8'd0;
    end else if (PCSrcE) begin
      // Everything in flight becomes stale; the word landing now too.
      fpc      <= {PCTargetE[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= discard + 8'(inflight) - 8'(imem_rvalid);
    end else begin
      if (issue) begin
        fpc  <= fpc + 32'd4;
        q_wr <= q_wr + AW'(1);
      end
      if (drop) discard <= discard - 8'd1;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        q_rd   <= q_rd + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(accept) - CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcq[q_wr] <= fpc;
    if (accept) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= pcq[q_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable imem model, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  fetch_unit #(
    .RESET_PC(RPC),
    .DEPTH(DEPTH),
    .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .StallF(StallF),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .InstrF(InstrF),
    .PCF(PCF),
    .PCPlus4F(PCPlus4F),
    .ValidF(ValidF)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int lat    = 1;
  int cyc    = 0;
  int n;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  logic [31:0] m_fifo[$];
  logic [31:0] m_infl[$];
  int          m_disc = 0;
  logic [31:0] m_fpc  = RPC;
  logic [31:0] seq_pc = RPC;
  logic        exp_req;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    imem_gnt = 1'b1;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!ValidF && cnt < 30) begin
      tick();
      #1;
      cnt++;
    end
    chk("wait_valid", ValidF, 1'b1);
  endtask

  // Instruction memory: fixed latency, in-order responses.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        mq.delete();
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'd0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= memf(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'd0;
      end
    end
  end

  // Reference model and per-cycle compare, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      exp_req = !rst && !PCSrcE &&
                (m_fifo.size() + m_infl.size() < DEPTH);
      chk("req", imem_req, exp_req);
      if (exp_req) chk("addr", imem_addr, m_fpc);
      if (!rst && m_fifo.size() > 0) begin
        chk("valid", ValidF, 1'b1);
        chk("pcf", PCF, m_fifo[0]);
        chk("pc4", PCPlus4F, m_fifo[0] + 32'd4);
        chk("instr", InstrF, memf(m_fifo[0]));
        chk("seq", PCF, seq_pc);
      end else begin
        chk("valid", ValidF, 1'b0);
        chk("nop", InstrF, NOP);
        chk("pcf0", PCF, 32'd0);
        chk("pc4_0", PCPlus4F, 32'd0);
      end
      if (!rst && imem_req && imem_gnt)
        mq.push_back('{cyc + lat, imem_addr});
      if (rst) begin
        m_fifo.delete();
        m_infl.delete();
        m_disc = 0;
        m_fpc  = RPC;
        seq_pc = RPC;
      end else if (PCSrcE) begin
        m_disc = m_disc + m_infl.size() - (imem_rvalid ? 1 : 0);
        m_fifo.delete();
        m_infl.delete();
        m_fpc  = PCTargetE & ~32'h3;
        seq_pc = PCTargetE & ~32'h3;
      end else begin
        if (m_fifo.size() > 0 && !StallF) begin
          void'(m_fifo.pop_front());
          seq_pc = seq_pc + 32'd4;
        end
        if (imem_rvalid) begin
          if (m_disc > 0) begin
            m_disc--;
          end else begin
            chk("resp_has_req", (m_infl.size() > 0), 1'b1);
            if (m_infl.size() > 0) m_fifo.push_back(m_infl.pop_front());
          end
        end
        if (exp_req && imem_gnt) begin
          m_infl.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and streaming
    do_reset(1);
    #1;
    chk("s1_req0", imem_req, 1'b1);
    chk("s1_addr0", imem_addr, 32'h0);
    tick(); #1;
    chk("s1_addr1", imem_addr, 32'h4);
    chk("s1_v1", ValidF, 1'b0);
    tick(); #1;
    chk("s1_v2", ValidF, 1'b1);
    chk("s1_pcf2", PCF, 32'h0);
    chk("s1_pc4_2", PCPlus4F, 32'h4);
    chk("s1_req2", imem_req, 1'b0);
    tick(); #1;
    chk("s1_pcf3", PCF, 32'h4);
    chk("s1_addr3", imem_addr, 32'h8);
    repeat (6) tick();

    // Stall mid-stream
    StallF = 1'b1;
    repeat (3) tick();
    #1;
    chk("s2_req_off", imem_req, 1'b0);
    chk("s2_held_v", ValidF, 1'b1);
    tick();
    StallF = 1'b0;
    repeat (10) tick();

    // Redirect with two requests in flight, latency 3
    do_reset(3);
    tick();
    tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    #1;
    chk("s3_req_redir", imem_req, 1'b0);
    tick();
    PCSrcE = 1'b0;
    #1;
    chk("s3_addr", imem_addr, 32'h100);
    wait_valid(n);
    chk("s3_lat", n, 4);
    chk("s3_pcf", PCF, 32'h100);

    // Redirect during stall with a simultaneous response
    do_reset(1);
    repeat (3) tick();
    StallF = 1'b1;
    #1;
    n = 0;
    while (!imem_rvalid && n < 10) begin
      tick(); #1; n++;
    end
    chk("s4_rv", imem_rvalid, 1'b1);
    PCSrcE = 1'b1;
    PCTargetE = 32'h40;
    #1;
    chk("s4_req_redir", imem_req, 1'b0);
    tick();
    PCSrcE = 1'b0;
    StallF = 1'b0;
    #1;
    chk("s4_empty", ValidF, 1'b0);
    chk("s4_req", imem_req, 1'b1);
    chk("s4_addr", imem_addr, 32'h40);
    wait_valid(n);
    chk("s4_lat", n, 2);
    chk("s4_pcf", PCF, 32'h40);

    // Grant backpressure, then misaligned redirect
    do_reset(1);
    imem_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s5_req_hold", imem_req, 1'b1);
      chk("s5_addr_hold", imem_addr, 32'h0);
      tick(); #1;
    end
    PCSrcE = 1'b1;
    PCTargetE = 32'h203;
    imem_gnt = 1'b1;
    tick();
    PCSrcE = 1'b0;
    #1;
    chk("s5_addr", imem_addr, 32'h200);
    wait_valid(n);
    chk("s5_pcf", PCF, 32'h200);
    repeat (4) tick();

    // Wrap-around, then asynchronous reset
    do_reset(1);
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    #1;
    chk("s6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("s6_addr_wrap", imem_addr, 32'h0);
    chk("s6_req_wrap", imem_req, 1'b1);
    tick(); #1;
    chk("s6_v", ValidF, 1'b1);
    chk("s6_pcf", PCF, 32'hFFFF_FFFC);
    chk("s6_pc4", PCPlus4F, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("s6_rst_v", ValidF, 1'b0);
    chk("s6_rst_instr", InstrF, NOP);
    chk("s6_rst_pcf", PCF, 32'h0);
    chk("s6_rst_pc4", PCPlus4F, 32'h0);
    chk("s6_rst_req", imem_req, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
